// File: rtl/hypot_sumsq_seq_if.sv
// Handshake bundle for the sum-of-squares operand stage: operand pair in,
// full-width X*X + Y*Y out, plus a busy status flag.
interface hypot_sumsq_seq_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           out_valid;
  logic           out_ready;
  logic [2*W:0]   out_sum;
  logic           busy;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/hypot_sumsq_seq.sv
// Serial shift-add X*X + Y*Y: one multiplier bit per cycle, W cycles per
// operand, result held in a registered output until the square-root stage takes it.
module hypot_sumsq_seq #(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst,
  hypot_sumsq_seq_if.slave   bus
);
  localparam int SW = 2*W + 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, MUL_X, MUL_Y, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_bit;

  // Zero-extended partial product: v << sh when bit sh of v is set.
  function automatic logic [SW-1:0] pp(input logic [W-1:0] v, input logic [CW-1:0] sh);
    logic [SW-1:0] ext;
    ext = {{(SW-W){1'b0}}, v};
    pp  = v[sh] ? (ext << sh) : '0;
  endfunction

  assign last_bit = (cnt_q == CW'(W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_x;
          y_d     = bus.in_y;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL_X;
        end
      end
      MUL_X: begin
        acc_d = acc_q + pp(x_q, cnt_q);
        if (last_bit) begin
          cnt_d   = '0;
          state_d = MUL_Y;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MUL_Y: begin
        acc_d = acc_q + pp(y_q, cnt_q);
        if (last_bit) begin
          // Final partial product lands in the output register on the same edge.
          cnt_d   = '0;
          sum_d   = acc_q + pp(y_q, cnt_q);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; nothing passes through from out_ready.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_sum   = sum_q;
endmodule
